ifetch: RTL and testbench
=========================

Name: ifetch

Overview:
- Instruction fetch stage, directly upstream of the instruction decoder.
- Owns the PC and issues word-aligned requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned words in a small FIFO and presents {instr, pc} to decode through a valid/ready handshake.
- Accepts redirects (jalr, reset vector) from execute, flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, instruction FIFO entries; also the cap on FIFO count + outstanding requests. Power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  byte address of fetch; bits [1:0] always 0.
- imem_rsp_valid  in  1  response word valid. In order, no backpressure, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  load new PC, flush pipeline.
- redirect_pc  in  32  redirect target.
- instr_valid  out  1  instr/instr_pc valid to decode.
- instr_ready  in  1  decode consumes the entry.
- instr  out  32  instruction word.
- instr_pc  out  32  address of instr.
- fetch_fault  out  1  sticky misaligned-redirect flag.

Behaviour:
- Reset (async, while rst_n=0):
  - pc=RESET_PC; FIFO empty; outstanding=0; drop=0; fetch_fault=0.
  - imem_req_valid=0, instr_valid=0, imem_req_addr=RESET_PC, instr=0, instr_pc=0.
- Request issue:
  - imem_req_valid = !fetch_fault && (count + outstanding < DEPTH), using registered values only.
  - imem_req_addr = pc.
  - On accept (valid && ready): pc += 4 (wraps modulo 2^32); outstanding += 1.
  - Once asserted, imem_req_valid and imem_req_addr stay stable until accepted, except on redirect.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If drop > 0: decrement drop, discard the word.
  - Else: push {data, pc_of_request} into the FIFO. A per-request PC queue of DEPTH entries tracks in-flight addresses.
  - Overflow is impossible by the credit rule; assert this in simulation.
- Output:
  - instr_valid = FIFO non-empty; instr and instr_pc come from the FIFO head.
  - Pop when instr_valid && instr_ready.
  - No response-to-output bypass: a word written at edge N is visible after edge N.
  - Zero-wait-state memory gives request accepted in cycle 1, response in cycle 2, instr_valid in cycle 3. Steady throughput is 1 instr/cycle.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority):
  - In the redirect cycle: instr_valid forced 0 and any pop ignored; imem_req_valid forced 0.
  - Next edge: FIFO cleared; pc=redirect_pc.
  - drop = outstanding (after this cycle's decrement) minus any response arriving this cycle, which is itself discarded.
  - Fetch resumes the cycle after the redirect.
  - Back-to-back redirects: the last one wins; drop accumulates correctly.
- Misaligned redirect (redirect_pc[1:0] != 0):
  - fetch_fault set, no further requests.
  - In-flight responses are drained and dropped.
  - Cleared only by an aligned redirect or reset.
- Counter widths: count, outstanding and drop are $clog2(DEPTH)+1 bits.
- Reset mid-operation: all state is cleared immediately. Responses to pre-reset requests are not the block's responsibility; memory is reset together with the block.

Decomposition:
- Shared package cpu_pkg:
  - XLEN=32 and INSTR_NOP=32'h0000_0013.
  - Typedef fetch_entry_t {logic [31:0] instr; logic [31:0] pc;}.
  - Constant RESET_PC default.
- Sub-module sync_fifo (parameterised width/depth, push/pop/flush, count, full/empty). Instantiated twice:
  - the fetch_entry_t FIFO;
  - the in-flight PC queue.

Test Plan:
- Reset release, ready=1, 1-cycle memory returning addr^32'hA5A5_0000 -> instr_valid first high 3 cycles after reset release. Stream pc 0x0,0x4,0x8,... one per cycle with matching data.
- Decode holds instr_ready=0 for 10 cycles -> exactly DEPTH=4 entries buffered, imem_req_valid low, no overflow. Release -> the 4 entries drain in order, with no gap before fetching resumes.
- imem_req_ready toggles every other cycle; response latency random 1-3 -> imem_req_addr stable while stalled. Output PCs strictly sequential, no duplicates or losses.
- Redirect to 0x100 with 2 requests outstanding and 2 buffered -> both late responses discarded, FIFO flushed. Next valid output is pc=0x100, followed by 0x104.
- Redirect in the same cycle as a response and a decode handshake -> handshake ignored, response dropped, no stale pc ever appears on instr_pc.
- Redirect to 0x102 -> fetch_fault=1, requests stop. Redirect to 0x200 -> fetch_fault=0, fetching resumes at 0x200. Finally, assert rst_n mid-stream -> all outputs return to reset values the same cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
package cpu_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Clear the byte-offset bits so the request address is always word aligned.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: imem request/response, execute redirect, decode handoff.
interface ifetch_if;
    import cpu_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; storage is reset so the head reads zero.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = mem_q[rd_ptr_q];
        count   = count_q;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited imem requests,
// buffers returned words for decode and handles flushing redirects.
module ifetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH    = 4
) (
    input logic       clk,
    input logic       rst_n,
    ifetch_if.master  bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned EW = $bits(fetch_entry_t);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_n;
    logic            req_valid_q;
    logic            req_valid_n;
    logic [CW-1:0]   drop_q;
    logic [CW-1:0]   drop_n;
    logic            fault_q;
    logic            fault_n;

    logic            flush;
    logic            req_fire;
    logic            rsp_push;
    logic            instr_pop;
    logic [SW-1:0]   count_n;
    logic [SW-1:0]   out_n;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [EW-1:0]   fifo_rdata;
    fetch_entry_t    head;
    fetch_entry_t    wr_entry;
    logic [CW-1:0]   pcq_count;
    logic            pcq_full;
    logic            pcq_empty;
    logic [XLEN-1:0] pcq_head;

    // A redirect masks both handshakes in its own cycle.
    assign bus.imem_req_valid = req_valid_q && !bus.redirect_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.instr_valid    = !fifo_empty && !bus.redirect_valid;
    assign bus.instr          = head.instr;
    assign bus.instr_pc       = head.pc;
    assign bus.fetch_fault    = fault_q;

    always_comb begin
        head      = fetch_entry_t'(fifo_rdata);
        flush     = bus.redirect_valid;
        req_fire  = bus.imem_req_valid && bus.imem_req_ready;
        instr_pop = bus.instr_valid && bus.instr_ready;
        rsp_push  = bus.imem_rsp_valid && (drop_q == '0) && !flush;
        wr_entry  = '{instr: bus.imem_rsp_data, pc: pcq_head};
    end

    // Next state; request valid is precomputed from next-cycle credits so it is registered.
    always_comb begin
        pc_n    = pc_q;
        drop_n  = drop_q;
        fault_n = fault_q;
        count_n = '0;
        if (flush) begin
            pc_n    = align_word(bus.redirect_pc);
            fault_n = |bus.redirect_pc[1:0];
            // Every request still in flight after this cycle's response belongs to the old stream.
            drop_n  = pcq_count - CW'(bus.imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc_n = pc_q + XLEN'(4);
            end
            if (bus.imem_rsp_valid && (drop_q != '0)) begin
                drop_n = drop_q - CW'(1);
            end
            count_n = SW'(fifo_count) + SW'(rsp_push) - SW'(instr_pop);
        end
        out_n       = SW'(pcq_count) + SW'(req_fire) - SW'(bus.imem_rsp_valid);
        req_valid_n = !fault_n && ((count_n + out_n) < SW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            drop_q      <= '0;
            fault_q     <= 1'b0;
        end else begin
            pc_q        <= pc_n;
            req_valid_q <= req_valid_n;
            drop_q      <= drop_n;
            fault_q     <= fault_n;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_entry_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rsp_push),
        .pop   (instr_pop),
        .flush (flush),
        .wdata (wr_entry),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // In-flight address queue; never flushed since dropped responses still pop it.
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_fire),
        .pop   (bus.imem_rsp_valid),
        .flush (1'b0),
        .wdata (pc_q),
        .rdata (pcq_head),
        .count (pcq_count),
        .full  (pcq_full),
        .empty (pcq_empty)
    );

    a_entry_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_push |-> (!fifo_full || instr_pop));
    a_pcq_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        req_fire |-> !pcq_full);
    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        bus.imem_rsp_valid |-> !pcq_empty);

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a behavioural in-order instruction memory.
module tb_ifetch;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ifetch_if bus ();

    ifetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic        fault;
        logic        has_out;
    } rvec_t;

    mreq_t       mq[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          n_out = 0;
    int          mem_lat = 1;
    int          rdy_mode = 0;
    logic        dec_ready = 1'b0;
    logic        rd_v = 1'b0;
    logic [31:0] rd_pc = '0;
    logic [31:0] exp_pc = '0;
    logic [31:0] last_out_pc = '0;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_addr = '0;
    logic        s_req_valid, s_ivalid, s_rsp, s_fault;
    logic [31:0] s_addr;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, sample #1 later, score handshakes seen this cycle.
    task automatic step();
        mreq_t r;
        @(negedge clk);
        case (rdy_mode)
            0:       bus.imem_req_ready = 1'b1;
            1:       bus.imem_req_ready = cyc[0];
            default: bus.imem_req_ready = 1'b0;
        endcase
        bus.instr_ready    = dec_ready;
        bus.redirect_valid = rd_v;
        bus.redirect_pc    = rd_pc;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = word_of(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
        #1;
        s_req_valid = bus.imem_req_valid;
        s_addr      = bus.imem_req_addr;
        s_ivalid    = bus.instr_valid;
        s_rsp       = bus.imem_rsp_valid;
        s_fault     = bus.fetch_fault;
        if (stall_prev && !rd_v) begin
            check("req_hold_valid", 32'(s_req_valid), 32'd1);
            check("req_hold_addr", s_addr, stall_addr);
        end
        stall_prev = s_req_valid && !bus.imem_req_ready;
        stall_addr = s_addr;
        if (rd_v) begin
            check("redir_instr_valid", 32'(s_ivalid), 32'd0);
            check("redir_req_valid", 32'(s_req_valid), 32'd0);
        end
        if (s_req_valid && bus.imem_req_ready) begin
            check("req_align", 32'(s_addr[1:0]), 32'd0);
            r.addr = s_addr;
            r.due  = cyc + ((mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat);
            mq.push_back(r);
        end
        if (s_ivalid && bus.instr_ready) begin
            check("out_pc", bus.instr_pc, exp_pc);
            check("out_instr", bus.instr, word_of(exp_pc));
            last_out_pc = bus.instr_pc;
            exp_pc      = exp_pc + 32'd4;
            n_out++;
        end
        if (rd_v) exp_pc = rd_pc;
        cyc++;
    endtask

    task automatic wait_out(input string name, input int target, input int max_cycles);
        int k = 0;
        while (n_out < target && k < max_cycles) begin
            step();
            k++;
        end
        check(name, 32'(n_out >= target), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] target);
        rd_v  = 1'b1;
        rd_pc = target;
        step();
        rd_v  = 1'b0;
    endtask

    // Async reset with immediate output checks, then release just after a negedge.
    task automatic do_reset();
        @(negedge clk);
        rst_n              = 1'b0;
        rd_v               = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_req_ready = 1'b0;
        mq.delete();
        stall_prev = 1'b0;
        #1;
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_req_addr", bus.imem_req_addr, 32'h0000_0000);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_instr_pc", bus.instr_pc, 32'd0);
        check("rst_fetch_fault", 32'(bus.fetch_fault), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 32'h0000_0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rvec_t vt[5];
        int    n0;
        int    k;
        logic  quiet;

        vt[0] = '{pc: 32'h0000_0102, fault: 1'b1, has_out: 1'b0};
        vt[1] = '{pc: 32'h0000_0200, fault: 1'b0, has_out: 1'b1};
        vt[2] = '{pc: 32'hFFFF_FFFC, fault: 1'b0, has_out: 1'b1};
        vt[3] = '{pc: 32'h0000_0401, fault: 1'b1, has_out: 1'b0};
        vt[4] = '{pc: 32'h0000_0040, fault: 1'b0, has_out: 1'b1};

        rst_n              = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;
        do_reset();

        // Reset release: request in cycle 1, response cycle 2, instr_valid cycle 3, then 1/cycle.
        dec_ready = 1'b1;
        step();
        check("t1_req_valid_c1", 32'(s_req_valid), 32'd1);
        check("t1_req_addr_c1", s_addr, 32'h0000_0000);
        check("t1_ivalid_c1", 32'(s_ivalid), 32'd0);
        step();
        check("t1_ivalid_c2", 32'(s_ivalid), 32'd0);
        step();
        check("t1_ivalid_c3", 32'(s_ivalid), 32'd1);
        n0 = n_out;
        repeat (10) step();
        check("t1_stream_rate", 32'(n_out - n0), 32'd10);

        // Decode backpressure fills the buffer and stops requests; release drains with no gap.
        dec_ready = 1'b0;
        repeat (10) step();
        check("t2_full_ivalid", 32'(s_ivalid), 32'd1);
        check("t2_full_req_valid", 32'(s_req_valid), 32'd0);
        dec_ready = 1'b1;
        n0 = n_out;
        repeat (8) step();
        check("t2_drain_nogap", 32'(n_out - n0), 32'd8);

        // Same fill, but memory refuses new requests: exactly DEPTH entries come out.
        dec_ready = 1'b0;
        repeat (10) step();
        rdy_mode  = 2;
        dec_ready = 1'b1;
        n0 = n_out;
        repeat (8) step();
        check("t2_exact_depth", 32'(n_out - n0), 32'd4);

        // Toggling request ready with random latency.
        rdy_mode = 1;
        mem_lat  = 0;
        n0 = n_out;
        repeat (40) step();
        check("t3_progress", 32'((n_out - n0) >= 10), 32'd1);

        // Quiesce, then build 2 buffered + 2 outstanding and redirect to 0x100.
        rdy_mode = 2;
        mem_lat  = 1;
        k = 0;
        do begin
            step();
            k++;
        end while ((s_ivalid || s_rsp || mq.size() != 0) && k < 20);
        check("t4_quiesce", 32'(!s_ivalid && !s_rsp && mq.size() == 0), 32'd1);
        dec_ready = 1'b0;
        rdy_mode  = 0;
        step();
        step();
        mem_lat = 5;
        step();
        step();
        check("t4_pre_ivalid", 32'(s_ivalid), 32'd1);
        mem_lat = 1;
        redirect(32'h0000_0100);
        check("t4_redir_no_rsp", 32'(s_rsp), 32'd0);
        dec_ready = 1'b1;
        n0 = n_out;
        wait_out("t4_first_timeout", n0 + 1, 20);
        check("t4_first_pc", last_out_pc, 32'h0000_0100);
        wait_out("t4_second_timeout", n0 + 2, 5);
        check("t4_second_pc", last_out_pc, 32'h0000_0104);

        // Redirect colliding with a response and a decode handshake.
        repeat (6) step();
        check("t5_pre_ivalid", 32'(s_ivalid), 32'd1);
        redirect(32'h0000_0300);
        n0 = n_out;
        wait_out("t5_first_timeout", n0 + 1, 20);
        check("t5_first_pc", last_out_pc, 32'h0000_0300);
        wait_out("t5_second_timeout", n0 + 2, 5);
        check("t5_second_pc", last_out_pc, 32'h0000_0304);

        // Redirect table: misaligned targets fault and stall, aligned ones resume (incl. wrap).
        for (int i = 0; i < 5; i++) begin
            redirect(vt[i].pc);
            step();
            check("vec_fault", 32'(s_fault), 32'(vt[i].fault));
            check("vec_req_valid", 32'(s_req_valid), 32'(!vt[i].fault));
            if (!vt[i].fault) check("vec_req_addr", s_addr, vt[i].pc);
            n0 = n_out;
            if (vt[i].has_out) begin
                wait_out("vec_first_timeout", n0 + 1, 20);
                check("vec_first_pc", last_out_pc, vt[i].pc);
                wait_out("vec_second_timeout", n0 + 2, 5);
                check("vec_second_pc", last_out_pc, vt[i].pc + 32'd4);
            end else begin
                quiet = 1'b1;
                repeat (10) begin
                    step();
                    if (s_req_valid) quiet = 1'b0;
                end
                check("vec_quiet_out", 32'(n_out - n0), 32'd0);
                check("vec_quiet_req", 32'(quiet), 32'd1);
                check("vec_fault_sticky", 32'(s_fault), 32'd1);
            end
        end

        // Reset mid-stream, restart from RESET_PC.
        repeat (3) step();
        check("t7_pre_ivalid", 32'(s_ivalid), 32'd1);
        do_reset();
        step();
        step();
        step();
        check("t7_restart_ivalid", 32'(s_ivalid), 32'd1);
        check("t7_restart_pc", last_out_pc, 32'h0000_0000);

        // Reset also clears a pending fault.
        redirect(32'h0000_0007);
        step();
        check("t7_fault_set", 32'(s_fault), 32'd1);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
